eth_rx_fcs_check: RTL and testbench
===================================

Name: eth_rx_fcs_check

Overview:
- Receive-side counterpart of the transmit CRC-32 generator.
- Takes the byte stream from the RX MAC front end, after preamble/SFD removal, at one byte per `clk`.
- Checks the trailing 4-byte FCS with the IEEE 802.3 CRC-32 and strips the FCS from the forwarded stream.
- Emits one status record per frame (CRC error, runt, oversize, PHY error, length) for the UDP offload path and the statistics counters.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes, FCS included.
- MAX_LEN, 1522, maximum legal frame length in bytes, FCS included.
- LEN_W, 16, width of the frame length counter and `stat_len`.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  frame byte; bit 0 is first on the wire.
- rx_valid  input  1  `rx_data` valid this cycle; gaps inside a frame are allowed.
- rx_last  input  1  qualifies the final byte of a frame; only meaningful with `rx_valid`.
- rx_err  input  1  PHY error on this byte; sticky for the frame.
- m_data  output  8  forwarded payload byte, FCS stripped.
- m_valid  output  1  `m_data` valid.
- m_last  output  1  last payload byte of the frame.
- m_bad  output  1  frame failed a check; valid only on the `m_last` beat, 0 otherwise.
- stat_valid  output  1  one-cycle pulse per frame, coincident with `m_last` when payload exists.
- stat_crc_err  output  1  residue mismatch.
- stat_runt  output  1  length < MIN_LEN.
- stat_oversize  output  1  length > MAX_LEN.
- stat_phy_err  output  1  `rx_err` seen in the frame.
- stat_len  output  LEN_W  total bytes including FCS; saturates at all-ones.

Behaviour:
- Reset: all outputs 0, CRC register 32'hFFFFFFFF, byte counter 0, delay line empty, state IDLE.
- Reset mid-frame discards the frame with no status.
- After reset, the next valid byte starts a new frame.
- CRC: same bit-serial polynomial 32'h04C11DB7 as the TX generator.
  - Per byte, process data bits 0..7, each XORed with register bit 31, shift left.
  - Init 32'hFFFFFFFF at frame start.
  - All bytes are included, FCS too.
  - Frame passes when the register after the last byte equals residue 32'hC704DD7B.
  - Use the combinational next value on the `rx_last` cycle.
- 4-byte delay line holds the most recent bytes.
  - Input byte k (0-based) with k>=4 releases byte k-4.
  - The four FCS bytes are never forwarded.
- All outputs are registered: `m_*` and `stat_*` appear on the cycle after the releasing input byte is sampled.
- FSM:
  - IDLE: on `rx_valid`, go to FILL with count=1.
  - FILL: while count<4, accept bytes with no output; the 4th byte moves to PASS.
  - PASS: each valid byte forwards one byte.
  - `rx_last` in any state returns to IDLE and produces status.
- Output on `rx_last`:
  - If N>=5: `m_valid=1`, `m_last=1`, with `m_bad = crc_err | runt | oversize | phy_err`.
  - `stat_valid` pulses in the same cycle as `m_last`.
  - If N<=4: no `m_valid`; `stat_valid` pulses with `stat_runt=1`, `stat_crc_err` per residue, `m_bad` stays 0.
- Length: counter increments per valid byte and saturates at 2^LEN_W-1. Oversize is flagged but the bytes are still forwarded.
- Back-to-back frames: a new frame's first byte may arrive the cycle after `rx_last`. CRC and counter reinit in that cycle; no byte is lost.
- `rx_valid=0` mid-frame: state, CRC and the delay line hold; `m_valid=0`.
- `stat_*` flags hold their values between pulses; they are only meaningful with `stat_valid`.

Test Plan:
- Payload "123456789" (31..39) then FCS 26 39 F4 CB, N=13 -> 9 output bytes 31..39, `m_last` on 39, `stat_crc_err=0`, `stat_runt=1`, `stat_len=13`, `m_bad=1`.
- 60-byte payload 00..3B with correct FCS, N=64 -> 60 bytes out unchanged, `m_bad=0`, all flags 0, `stat_len=64`, output lags input by 5 cycles (4-byte hold plus 1 register).
- Same 64-byte frame with byte 10 bit 3 flipped -> `stat_crc_err=1`, `m_bad=1`, 60 bytes still forwarded. Separately, `rx_err` on byte 20 -> `stat_phy_err=1`.
- Two correct 64-byte frames back-to-back, then a 1600-byte frame -> two clean status pulses, then `stat_oversize=1`, `stat_len=1600`.
- 3-byte frame, then a 64-byte frame with `rx_valid` gaps of 1-3 cycles -> first: `stat_valid` with `stat_runt=1` and no `m_valid`; second passes with 60 bytes out.
- `rst` asserted at byte 30 of a frame -> outputs 0 immediately; the following correct frame passes cleanly.

Source files
------------

// File: rtl/eth_rx_fcs_check.sv
// Receive-side FCS checker: runs the IEEE 802.3 CRC-32 over every byte of a
// frame (FCS included), holds the last four bytes back so the FCS is never
// forwarded, and emits one status record per frame.
module eth_rx_fcs_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_last,
    input  logic             rx_err,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    output logic             m_bad,
    output logic             stat_valid,
    output logic             stat_crc_err,
    output logic             stat_runt,
    output logic             stat_oversize,
    output logic             stat_phy_err,
    output logic [LEN_W-1:0] stat_len
);

    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PASS
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        crc_q, crc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               phy_q, phy_d;
    logic [31:0]        dly_q, dly_d;

    logic               frame_start;
    logic [31:0]        crc_base, crc_next;
    logic [LEN_W-1:0]   len_base, len_next;
    logic               phy_next;
    logic               fwd;
    logic               frame_done;
    logic               crc_err, runt, oversize;

    logic [7:0]         m_data_q;
    logic               m_valid_q, m_last_q, m_bad_q;
    logic               stat_valid_q, stat_crc_err_q, stat_runt_q;
    logic               stat_oversize_q, stat_phy_err_q;
    logic [LEN_W-1:0]   stat_len_q;

    // Bit-serial CRC step over one byte, bit 0 first as it appears on the wire.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    // Per-byte datapath values; a byte seen in IDLE starts a fresh frame so the
    // CRC, length and PHY-error accumulators restart without losing that byte.
    always_comb begin
        frame_start = (state_q == IDLE);
        crc_base    = frame_start ? CRC_INIT : crc_q;
        len_base    = frame_start ? '0 : len_q;
        crc_next    = crc_byte(crc_base, rx_data);
        len_next    = (len_base == '1) ? len_base : len_base + 1'b1;
        phy_next    = (frame_start ? 1'b0 : phy_q) | rx_err;
        fwd         = rx_valid && (state_q == PASS);
        frame_done  = rx_valid && rx_last;
        crc_err     = (crc_next != CRC_RESIDUE);
        runt        = (len_next < LEN_W'(MIN_LEN));
        oversize    = (len_next > LEN_W'(MAX_LEN));
    end

    // Next-state logic: fill the 4-byte hold, then forward one byte per input
    // byte; the final byte of a frame always returns to IDLE.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
        phy_d   = phy_q;
        dly_d   = dly_q;
        if (rx_valid) begin
            crc_d = crc_next;
            len_d = len_next;
            phy_d = phy_next;
            dly_d = {dly_q[23:0], rx_data};
            case (state_q)
                IDLE:    state_d = FILL;
                FILL:    state_d = (len_next == LEN_W'(4)) ? PASS : FILL;
                PASS:    state_d = PASS;
                default: state_d = IDLE;
            endcase
            if (rx_last) begin
                state_d = IDLE;
            end
        end
    end

    // Frame state, CRC, length and delay line registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= CRC_INIT;
            len_q   <= '0;
            phy_q   <= 1'b0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
            phy_q   <= phy_d;
            dly_q   <= dly_d;
        end
    end

    // Registered output stage; status flags only change when a frame ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_q        <= '0;
            m_valid_q       <= 1'b0;
            m_last_q        <= 1'b0;
            m_bad_q         <= 1'b0;
            stat_valid_q    <= 1'b0;
            stat_crc_err_q  <= 1'b0;
            stat_runt_q     <= 1'b0;
            stat_oversize_q <= 1'b0;
            stat_phy_err_q  <= 1'b0;
            stat_len_q      <= '0;
        end else begin
            m_valid_q    <= fwd;
            m_data_q     <= fwd ? dly_q[31:24] : '0;
            m_last_q     <= fwd && rx_last;
            m_bad_q      <= fwd && rx_last && (crc_err || runt || oversize || phy_next);
            stat_valid_q <= frame_done;
            if (frame_done) begin
                stat_crc_err_q  <= crc_err;
                stat_runt_q     <= runt;
                stat_oversize_q <= oversize;
                stat_phy_err_q  <= phy_next;
                stat_len_q      <= len_next;
            end
        end
    end

    assign m_data        = m_data_q;
    assign m_valid       = m_valid_q;
    assign m_last        = m_last_q;
    assign m_bad         = m_bad_q;
    assign stat_valid    = stat_valid_q;
    assign stat_crc_err  = stat_crc_err_q;
    assign stat_runt     = stat_runt_q;
    assign stat_oversize = stat_oversize_q;
    assign stat_phy_err  = stat_phy_err_q;
    assign stat_len      = stat_len_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Testbench for eth_rx_fcs_check: drives directed and random frames and checks
// the forwarded stream and status records against a reflected-CRC frame model.
module tb_eth_rx_fcs_check;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1522;
    localparam int LEN_W   = 16;

    typedef logic [7:0] byteq_t [$];
    typedef bit         bitq_t  [$];
    typedef int         intq_t  [$];

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       bad;
        int         cyc;
    } beat_t;

    typedef struct {
        logic             crc;
        logic             runt;
        logic             over;
        logic             phy;
        logic [LEN_W-1:0] len;
        int               cyc;
    } stat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_last;
    logic             rx_err;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_bad;
    logic             stat_valid;
    logic             stat_crc_err;
    logic             stat_runt;
    logic             stat_oversize;
    logic             stat_phy_err;
    logic [LEN_W-1:0] stat_len;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    beat_t obsBeats[$];
    beat_t expBeats[$];
    stat_t obsStats[$];
    stat_t expStats[$];

    eth_rx_fcs_check #(
        .MIN_LEN(MIN_LEN),
        .MAX_LEN(MAX_LEN),
        .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_last(rx_last),
        .rx_err(rx_err),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_last(m_last),
        .m_bad(m_bad),
        .stat_valid(stat_valid),
        .stat_crc_err(stat_crc_err),
        .stat_runt(stat_runt),
        .stat_oversize(stat_oversize),
        .stat_phy_err(stat_phy_err),
        .stat_len(stat_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Collect every output beat and status pulse with the cycle it appeared in.
    always @(negedge clk) begin
        beat_t b;
        stat_t s;
        if (rst === 1'b0) begin
            if (m_valid) begin
                b.d = m_data; b.last = m_last; b.bad = m_bad; b.cyc = cyc;
                obsBeats.push_back(b);
            end else begin
                checkOutput("idle_last_bad", 32'({m_last, m_bad}), 32'd0);
            end
            if (stat_valid) begin
                s.crc = stat_crc_err; s.runt = stat_runt; s.over = stat_oversize;
                s.phy = stat_phy_err; s.len = stat_len; s.cyc = cyc;
                obsStats.push_back(s);
            end
        end
    end

    // Standard reflected CRC-32 of a payload, appended least significant byte first.
    function automatic byteq_t withFcs(input byteq_t p);
        byteq_t      f;
        logic [31:0] c;
        f = p;
        c = 32'hFFFFFFFF;
        foreach (p[i]) begin
            c = c ^ 32'(p[i]);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
        return f;
    endfunction

    function automatic byteq_t seqPayload(input int n, input int start);
        byteq_t p;
        for (int i = 0; i < n; i++) p.push_back(8'(start + i));
        return p;
    endfunction

    function automatic byteq_t randPayload(input int n);
        byteq_t p;
        for (int i = 0; i < n; i++) p.push_back(8'($urandom));
        return p;
    endfunction

    function automatic bitq_t noErr(input int n);
        bitq_t e;
        for (int i = 0; i < n; i++) e.push_back(1'b0);
        return e;
    endfunction

    // Frame-level reference: a frame is good when its reflected CRC over all
    // bytes leaves the well-known residue; everything but the last four bytes
    // is forwarded, each appearing right after the byte four places later.
    function automatic void modelFrame(input byteq_t b, input bitq_t e, input intq_t inCyc);
        int          n;
        logic [31:0] r;
        bit          phy;
        bit          bad;
        stat_t       s;
        beat_t       bt;
        n   = b.size();
        r   = 32'hFFFFFFFF;
        phy = 1'b0;
        for (int i = 0; i < n; i++) begin
            r = r ^ 32'(b[i]);
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
            phy = phy | e[i];
        end
        s.crc  = (r != 32'hDEBB20E3);
        s.runt = (n < MIN_LEN);
        s.over = (n > MAX_LEN);
        s.phy  = phy;
        s.len  = (n > 65535) ? 16'hFFFF : 16'(n);
        s.cyc  = inCyc[n-1];
        expStats.push_back(s);
        bad = s.crc | s.runt | s.over | s.phy;
        for (int j = 0; j + 4 < n; j++) begin
            bt.d    = b[j];
            bt.last = (j == n - 5);
            bt.bad  = bt.last & bad;
            bt.cyc  = inCyc[j+4];
            expBeats.push_back(bt);
        end
    endfunction

    // Drive one frame, optionally with 1-3 idle cycles between bytes, and
    // record its expected outputs.
    task automatic applyStimulus(input byteq_t b, input bitq_t e, input bit gaps);
        intq_t inCyc;
        int    n;
        n = b.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; rx_data = 8'($urandom);
                end
            end
            @(negedge clk);
            rx_data  = b[i];
            rx_valid = 1'b1;
            rx_last  = (i == n - 1);
            rx_err   = e[i];
            inCyc.push_back(cyc + 1);
        end
        modelFrame(b, e, inCyc);
    endtask

    task automatic idleCycles(input int n);
        @(negedge clk);
        rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic compareQueues(input string tag);
        int nb;
        int ns;
        checkOutput({tag, "_nbeats"}, 32'(obsBeats.size()), 32'(expBeats.size()));
        checkOutput({tag, "_nstats"}, 32'(obsStats.size()), 32'(expStats.size()));
        nb = (obsBeats.size() < expBeats.size()) ? obsBeats.size() : expBeats.size();
        ns = (obsStats.size() < expStats.size()) ? obsStats.size() : expStats.size();
        for (int i = 0; i < nb; i++) begin
            checkOutput({tag, "_data"}, 32'(obsBeats[i].d), 32'(expBeats[i].d));
            checkOutput({tag, "_last"}, 32'(obsBeats[i].last), 32'(expBeats[i].last));
            checkOutput({tag, "_bad"}, 32'(obsBeats[i].bad), 32'(expBeats[i].bad));
            checkOutput({tag, "_beatcyc"}, 32'(obsBeats[i].cyc), 32'(expBeats[i].cyc));
        end
        for (int i = 0; i < ns; i++) begin
            checkOutput({tag, "_crc"}, 32'(obsStats[i].crc), 32'(expStats[i].crc));
            checkOutput({tag, "_runt"}, 32'(obsStats[i].runt), 32'(expStats[i].runt));
            checkOutput({tag, "_over"}, 32'(obsStats[i].over), 32'(expStats[i].over));
            checkOutput({tag, "_phy"}, 32'(obsStats[i].phy), 32'(expStats[i].phy));
            checkOutput({tag, "_len"}, 32'(obsStats[i].len), 32'(expStats[i].len));
            checkOutput({tag, "_statcyc"}, 32'(obsStats[i].cyc), 32'(expStats[i].cyc));
        end
        obsBeats.delete(); expBeats.delete(); obsStats.delete(); expStats.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mdata"}, 32'(m_data), 32'd0);
        checkOutput({tag, "_mflags"}, 32'({m_valid, m_last, m_bad}), 32'd0);
        checkOutput({tag, "_sflags"},
                    32'({stat_valid, stat_crc_err, stat_runt, stat_oversize, stat_phy_err}), 32'd0);
        checkOutput({tag, "_slen"}, 32'(stat_len), 32'd0);
    endtask

    initial begin
        byteq_t f;
        byteq_t g;
        bitq_t  e;
        int     n;
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        idleCycles(2);

        // "123456789" with its well-known FCS
        f = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};
        applyStimulus(f, noErr(13), 1'b0);
        idleCycles(4);
        compareQueues("check123");

        // Minimum-length good frame, then single-bit corruption, then PHY error
        f = withFcs(seqPayload(60, 0));
        applyStimulus(f, noErr(64), 1'b0);
        idleCycles(4);
        compareQueues("good64");
        g = f;
        g[10] = g[10] ^ 8'h08;
        applyStimulus(g, noErr(64), 1'b0);
        idleCycles(4);
        compareQueues("crcerr64");
        e = noErr(64);
        e[20] = 1'b1;
        applyStimulus(f, e, 1'b0);
        idleCycles(4);
        compareQueues("phyerr64");

        // Back-to-back good frames followed by an oversize frame
        applyStimulus(f, noErr(64), 1'b0);
        applyStimulus(f, noErr(64), 1'b0);
        idleCycles(2);
        g = withFcs(randPayload(1596));
        applyStimulus(g, noErr(1600), 1'b0);
        idleCycles(4);
        compareQueues("b2b_oversize");

        // Tiny runt frame then a gapped good frame
        applyStimulus(randPayload(3), noErr(3), 1'b0);
        idleCycles(2);
        applyStimulus(f, noErr(64), 1'b1);
        idleCycles(4);
        compareQueues("runt3_gapped");

        // Reset in the middle of a frame, then a clean frame
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            rx_data = f[i]; rx_valid = 1'b1; rx_last = 1'b0; rx_err = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkAllZero("rst_mid");
        repeat (2) @(negedge clk);
        obsBeats.delete(); obsStats.delete();
        rst = 1'b0;
        idleCycles(1);
        applyStimulus(f, noErr(64), 1'b0);
        idleCycles(4);
        compareQueues("after_rst");

        // Random frames: lengths around the boundaries, corruption, errors, gaps
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, 120);
            if (n >= 4 && $urandom_range(0, 1) == 1) g = withFcs(randPayload(n - 4));
            else g = randPayload(n);
            if ($urandom_range(0, 3) == 0) begin
                int idx;
                idx = $urandom_range(0, n - 1);
                g[idx] = g[idx] ^ 8'(1 << $urandom_range(0, 7));
            end
            e = noErr(n);
            if ($urandom_range(0, 9) == 0) e[$urandom_range(0, n - 1)] = 1'b1;
            applyStimulus(g, e, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(0, 3));
        end
        idleCycles(6);
        compareQueues("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
